// File: rtl/acorn_fbk_ksg.sv
// ACORN-128 keystream / feedback bit generator.
// Computes one ks and one f bit per cycle from a 293-bit state image.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   state_in  : ACORN state, bit i = S[i]
//   ca_in     : control bit ca
//   cb_in     : control bit cb
//   in_valid  : qualifies state_in / ca_in / cb_in
//   ks_out    : registered keystream bit
//   fout      : registered feedback bit
//   out_valid : ks_out / fout carry a fresh result
module acorn_fbk_ksg (
  input  logic         clk,
  input  logic         rst,
  input  logic [292:0] state_in,
  input  logic         ca_in,
  input  logic         cb_in,
  input  logic         in_valid,
  output logic         ks_out,
  output logic         fout,
  output logic         out_valid
);

  function automatic logic maj(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) ^ (~x & z);
  endfunction

  logic ks_d;
  logic f_d;
  logic ks_q;
  logic f_q;
  logic vld_q;

  // Only the taps below are read; the rest of the state is don't-care.
  always_comb begin
    ks_d = state_in[12]
         ^ state_in[154]
         ^ maj(state_in[235], state_in[61], state_in[193])
         ^ ch(state_in[230], state_in[111], state_in[66]);
    f_d  = state_in[0]
         ^ ~state_in[107]
         ^ maj(state_in[244], state_in[23], state_in[160])
         ^ (ca_in & state_in[196])
         ^ (cb_in & ks_d);
  end

  // Idle cycles keep the last result visible but drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_q  <= 1'b0;
      f_q   <= 1'b0;
      vld_q <= 1'b0;
    end else if (in_valid) begin
      ks_q  <= ks_d;
      f_q   <= f_d;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign ks_out    = ks_q;
  assign fout      = f_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_acorn_fbk_ksg.sv
// Bench for acorn_fbk_ksg.
// Directed vectors plus random stream against a parity-sum reference.
module tb_acorn_fbk_ksg;

  logic         clk;
  logic         rst;
  logic [292:0] state_in;
  logic         ca_in;
  logic         cb_in;
  logic         in_valid;
  logic         ks_out;
  logic         fout;
  logic         out_valid;

  int n_chk;
  int n_err;

  logic m_ks;
  logic m_f;
  logic m_v;

  acorn_fbk_ksg dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .ca_in     (ca_in),
    .cb_in     (cb_in),
    .in_valid  (in_valid),
    .ks_out    (ks_out),
    .fout      (fout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic  got,
    input logic  exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference: count ones and take parity; maj as "at least two".
  function automatic int ref_ks(input logic [292:0] s);
    int sum;
    int m;
    int c;
    m = (int'(s[235]) + int'(s[61]) + int'(s[193]) >= 2) ? 1 : 0;
    c = s[230] ? int'(s[111]) : int'(s[66]);
    sum = int'(s[12]) + int'(s[154]) + m + c;
    return sum % 2;
  endfunction

  function automatic int ref_f(
    input logic [292:0] s,
    input logic         ca,
    input logic         cb
  );
    int sum;
    int m;
    m = (int'(s[244]) + int'(s[23]) + int'(s[160]) >= 2) ? 1 : 0;
    sum = int'(s[0]) + (1 - int'(s[107])) + m;
    if (ca && s[196]) sum++;
    if (cb && ref_ks(s) == 1) sum++;
    return sum % 2;
  endfunction

  function automatic logic [292:0] rep(input logic [7:0] b);
    logic [292:0] s;
    s = '0;
    for (int i = 0; i < 256; i++) s[i] = b[i % 8];
    return s;
  endfunction

  function automatic logic [292:0] rnd_state();
    logic [292:0] s;
    s = '0;
    for (int i = 0; i < 293; i++) s[i] = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic step(
    input string        tag,
    input logic [292:0] s,
    input logic         ca,
    input logic         cb,
    input logic         v,
    input logic         r
  );
    @(negedge clk);
    state_in = s;
    ca_in    = ca;
    cb_in    = cb;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    if (r) begin
      m_ks = 1'b0;
      m_f  = 1'b0;
      m_v  = 1'b0;
    end else if (v) begin
      m_ks = (ref_ks(s) == 1);
      m_f  = (ref_f(s, ca, cb) == 1);
      m_v  = 1'b1;
    end else begin
      m_v  = 1'b0;
    end
    #1;
    chk({tag, "_ks"}, ks_out, m_ks);
    chk({tag, "_f"}, fout, m_f);
    chk({tag, "_v"}, out_valid, m_v);
  endtask

  logic [292:0] s12;
  logic [292:0] ones;
  logic [7:0]   pat [5];

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    state_in = '0;
    ca_in    = 1'b0;
    cb_in    = 1'b0;
    in_valid = 1'b0;
    n_chk    = 0;
    n_err    = 0;
    m_ks     = 1'b0;
    m_f      = 1'b0;
    m_v      = 1'b0;
    ones     = '1;
    s12      = '0;
    s12[12]  = 1'b1;
    pat[0] = 8'h55;
    pat[1] = 8'h5F;
    pat[2] = 8'h50;
    pat[3] = 8'hF0;
    pat[4] = 8'hC3;

    // Reset held two cycles, with in_valid high to show rst priority.
    step("rst0", ones, 1'b1, 1'b1, 1'b1, 1'b1);
    step("rst1", ones, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_ks", ks_out, 1'b0);
    chk("rst_f", fout, 1'b0);
    chk("rst_v", out_valid, 1'b0);

    step("zero", '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("zero_ks_c", ks_out, 1'b0);
    chk("zero_f_c", fout, 1'b1);
    chk("zero_v_c", out_valid, 1'b1);

    step("one00", ones, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("one00_ks_c", ks_out, 1'b0);
    chk("one00_f_c", fout, 1'b0);
    step("one10", ones, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("one10_f_c", fout, 1'b1);
    step("one11", ones, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("one11_f_c", fout, 1'b1);
    step("one01", ones, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("one01_f_c", fout, 1'b0);

    step("s12c0", s12, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s12c0_ks_c", ks_out, 1'b1);
    chk("s12c0_f_c", fout, 1'b1);
    step("s12c1", s12, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("s12c1_f_c", fout, 1'b0);

    step("p55", rep(8'h55), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p55_ks_c", ks_out, 1'b0);
    chk("p55_f_c", fout, 1'b1);

    // Back-to-back stream then idle: outputs held, valid drops.
    for (int i = 0; i < 5; i++)
      step($sformatf("b2b%0d", i), rep(pat[i]), 1'b1, 1'b1, 1'b1, 1'b0);
    step("idle0", ones, 1'b1, 1'b0, 1'b0, 1'b0);
    step("idle1", '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Mid-stream reset discards the pending result.
    step("mid0", s12, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mid1", ones, 1'b1, 1'b0, 1'b1, 1'b1);
    step("mid2", s12, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      step("rnd", rnd_state(),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
